// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier and the downstream
// divider controller: FSM state encodings and default widths.
package mul_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add partial-product step: conditionally add the multiplicand
// into the accumulator, then shift {carry,acc,mq} right by one so the
// carry lands in the MSB of acc.
module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mq_next
);

  logic [WIDTH:0] sum;

  // Add-then-shift datapath for a single multiplier bit.
  always_comb begin
    sum = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    {acc_next, mq_next} = {sum, mq[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul32_64_seq.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one bit per
// clock, with a start/busy/done handshake. Produces the dividend for the
// downstream divider.
// Optional build macro: MUL_SIGNED_EN (two's complement A, B and P).
module mul32_64_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_t          state;
  logic [CNT_W-1:0]    count;
  logic [WIDTH-1:0]    acc;
  logic [WIDTH-1:0]    mq;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH-1:0]    acc_next;
  logic [WIDTH-1:0]    mq_next;
  logic [WIDTH-1:0]    a_load;
  logic [WIDTH-1:0]    b_load;
  logic [2*WIDTH-1:0]  result;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mq       (mq),
    .mcand    (mcand),
    .acc_next (acc_next),
    .mq_next  (mq_next)
  );

`ifdef MUL_SIGNED_EN
  logic neg;

  // Operands enter the unsigned core as magnitudes; the most negative value
  // maps onto its own bit pattern, which is the correct unsigned magnitude.
  always_comb begin
    a_load = A[WIDTH-1] ? -A : A;
    b_load = B[WIDTH-1] ? -B : B;
    result = neg ? -{acc_next, mq_next} : {acc_next, mq_next};
  end

  // Result sign is fixed at accept time so operands may change during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg <= 1'b0;
    end else if (state == S_IDLE && start) begin
      neg <= A[WIDTH-1] ^ B[WIDTH-1];
    end
  end
`else
  // Unsigned build: operands and result pass straight through.
  always_comb begin
    a_load = A;
    b_load = B;
    result = {acc_next, mq_next};
  end
`endif

  // Control FSM, iteration counter and datapath registers with registered
  // busy/done; the product register only changes on the final RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      P     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            mcand <= a_load;
            mq    <= b_load;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          mq    <= mq_next;
          count <= count + 1'b1;
          if (count == LAST_CNT) begin
            P     <= result;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul32_64_seq.sv
// Self-checking bench for mul32_64_seq: a vector table (fixed corner cases
// plus random operands scored by an arithmetic reference), followed by
// hand-written sequences for start-held-high, mid-run reset and the
// product-hold / DONE-cycle start behaviour.
module tb_mul32_64_seq;

  localparam int LATENCY = 32;
  localparam int TIMEOUT = 100;
  localparam int NVEC    = 14;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [63:0] P;

  int checks;
  int errors;

  mul32_64_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference product straight from integer arithmetic.
  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    longint unsigned ua;
    longint unsigned ub;
    ua = {32'd0, a};
    ub = {32'd0, b};
    return 64'(ua * ub);
`endif
  endfunction

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one full multiply from the IDLE state and checks latency, result,
  // product hold during RUN, and the return to IDLE. With pokeDone set, a
  // start pulse is driven only during the DONE cycle and must be ignored.
  task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp, input bit pokeDone);
    logic [63:0] prevP;
    bit          stable;
    int          n;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    prevP = P;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, " busy after accept"}, {63'd0, busy}, 64'd1);
    n = 0;
    stable = 1'b1;
    while (!done && n < TIMEOUT) begin
      if (P !== prevP) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    checkOutput({name, " latency"}, 64'(n), 64'(LATENCY));
    checkOutput({name, " P"}, P, exp);
    checkOutput({name, " P held in RUN"}, {63'd0, stable}, 64'd1);
    if (pokeDone) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, " busy after done"}, {63'd0, busy}, 64'd0);
    checkOutput({name, " done one cycle"}, {63'd0, done}, 64'd0);
    if (pokeDone) begin
      @(negedge clk);
      checkOutput({name, " DONE-cycle start ignored"}, {63'd0, busy}, 64'd0);
    end
  endtask

  vec_t vecs [NVEC];

  initial begin
    int doneCount;
    int firstAt;
    int secondAt;
    logic [63:0] firstP;
    logic [63:0] secondP;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    A      = '0;
    B      = '0;

`ifdef MUL_SIGNED_EN
    vecs[0] = '{32'd3,          32'd5,          64'd15};
    vecs[1] = '{32'hFFFFFFFD,   32'd5,          64'hFFFFFFFFFFFFFFF1};
    vecs[2] = '{32'h80000000,   32'hFFFFFFFF,   64'h0000000080000000};
    vecs[3] = '{32'hFFFFFFFC,   32'hFFFFFFFC,   64'd16};
    vecs[4] = '{32'h80000000,   32'h80000000,   64'h4000000000000000};
    vecs[5] = '{32'd0,          32'hFFFFFFFF,   64'd0};
`else
    vecs[0] = '{32'd3,          32'd5,          64'd15};
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001};
    vecs[2] = '{32'h80000000,   32'd2,          64'h0000000100000000};
    vecs[3] = '{32'd0,          32'd0,          64'd0};
    vecs[4] = '{32'h12345678,   32'd7,          64'h000000007F6E5D48};
    vecs[5] = '{32'hFFFFFFFF,   32'd1,          64'h00000000FFFFFFFF};
`endif
    for (int i = 6; i < NVEC; i++) begin
      vecs[i].a   = $urandom;
      vecs[i].b   = $urandom;
      vecs[i].exp = refProduct(vecs[i].a, vecs[i].b);
    end

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset done", {63'd0, done}, 64'd0);
    checkOutput("reset P", P, 64'd0);
    rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
    end

    $display("[TB] start held high, A changes during RUN");
    @(negedge clk);
    A = 32'd0;
    B = 32'h12345678;
    start = 1'b1;
    @(negedge clk);
    A = 32'd7;
    doneCount = 0;
    firstAt = -1;
    secondAt = -1;
    firstP = '1;
    secondP = '1;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      if (done) begin
        doneCount++;
        if (doneCount == 1) begin
          firstAt = n;
          firstP = P;
        end else if (doneCount == 2) begin
          secondAt = n;
          secondP = P;
        end
      end
      if (n == 66) start = 1'b0;
    end
    checkOutput("held start done count", 64'(doneCount), 64'd2);
    checkOutput("held start first latency", 64'(firstAt), 64'd32);
    checkOutput("held start first P", firstP, 64'd0);
    checkOutput("held start second latency", 64'(secondAt), 64'd66);
    checkOutput("held start second P", secondP, refProduct(32'd7, 32'h12345678));
    checkOutput("held start idle after", {63'd0, busy}, 64'd0);

    $display("[TB] reset during RUN");
    @(negedge clk);
    A = 32'd9;
    B = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 9; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", {63'd0, busy}, 64'd0);
    checkOutput("abort done", {63'd0, done}, 64'd0);
    checkOutput("abort P", P, 64'd0);
    doneCount = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) doneCount++;
    end
    checkOutput("abort no activity", 64'(doneCount), 64'd0);
    applyStimulus("after abort", 32'd7, 32'd6, 64'd42, 1'b0);

    $display("[TB] product hold and DONE-cycle start");
    applyStimulus("prev 15", 32'd3, 32'd5, 64'd15, 1'b0);
    applyStimulus("hold then 1", 32'd1, 32'd1, 64'd1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul32_64_seq.md
Name: mul32_64_seq

Overview:
- Sequential shift-add multiplier: 32x32 operands in, 64-bit product out, one partial-product step per clock.
- Sits directly upstream of the team's 64/32 sequential divider (div64_32) and produces its 64-bit dividend operand.
- Adds a start/busy/done handshake, so the control path can chain multiply-then-divide without a free-running loop.

Parameters:
- WIDTH, 32, operand width; product width is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  multiplicand; captured on the accepting edge.
- B  input  WIDTH  multiplier; captured on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when P is updated.
- P  output  2*WIDTH  product register; holds its value until the next result or reset.

Behaviour:
- Reset is checked first on every edge: state=IDLE, count=0, acc=0, mq=0, mcand=0, P=0, busy=0, done=0.
- Reset mid-operation aborts the operation; no done pulse is produced for it.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=1, done=1.
- IDLE -> RUN on an edge with start=1:
  - mcand<=A, mq<=B, acc<=0, count<=0.
  - Operands are not sampled afterwards; A and B may change freely during RUN.
- RUN, each edge:
  - sum = {1'b0,acc} + (mq[0] ? {1'b0,mcand} : 0), WIDTH+1 bits wide.
  - {acc,mq} <= {sum,mq} >> 1, so the carry enters the MSB of acc.
  - count<=count+1.
- RUN -> DONE on the edge where count==WIDTH-1, i.e. the WIDTH-th RUN edge. On that edge P is loaded with the final {acc,mq}.
- DONE -> IDLE unconditionally on the next edge.
- Latency:
  - done is high during the cycle after the WIDTH-th RUN edge: 32 clocks after the accepting edge for WIDTH=32.
  - The next start can be accepted 34 edges after the previous accept.
- start is ignored in RUN and DONE; it is not queued.
- Holding start high continuously restarts the multiplier on every IDLE visit.
- Arithmetic is unsigned modulo nothing: the full 2*WIDTH product is exact, with no overflow flag.
- Zero operands take the full latency (no early termination).

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined: A, B and P are two's complement.
  - On accept, mcand and mq load the magnitudes |A| and |B|, and neg <= A[MSB]^B[MSB].
  - On the DONE-loading edge, P <= neg ? -{acc,mq} : {acc,mq}.
  - Latency is identical to the unsigned build.
  - -2^31 is handled as the unsigned magnitude 0x80000000.
- Undefined: purely unsigned; no neg register and no negation logic.

Decomposition:
- Shared package mul_pkg holds:
  - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - default WIDTH=32 and CNT_W=6 constants.
  - The downstream divider controller reuses the same package.
- One sub-module is natural: mul_step, a combinational block that takes acc, mq and mcand and returns the next {acc,mq}. It contains the (WIDTH+1)-bit add and the shift.
- The top module holds only the FSM, the counter and the registers.

Test Plan:
- Unsigned small: start with A=3, B=5 -> done pulses exactly 32 clocks after the accept edge; P=64'd15; busy falls the cycle after done.
- Unsigned max: A=B=0xFFFFFFFF -> P=0xFFFFFFFE00000001. Carry path check: A=0x80000000, B=2 -> P=0x100000000.
- start held high through the whole run, A=0, B=0x12345678, with A changed to 7 during RUN -> exactly one done per IDLE visit; first P=0; the second operation (accepted after returning to IDLE with A=7) gives P=0x7F6E5D48.
- Reset on the 10th RUN edge -> next cycle busy=0, done=0, P=0, no done pulse. Then start with A=7, B=6 -> P=42 after 32 clocks.
- Previous P=15, new start A=B=1 -> P stays 15 throughout RUN and changes to 1 exactly when done rises. A start pulse applied only in the DONE cycle is ignored (busy stays 0 afterwards).
- MUL_SIGNED_EN defined:
  - A=-3, B=5 -> P=0xFFFFFFFFFFFFFFF1.
  - A=0x80000000, B=0xFFFFFFFF -> P=0x0000000080000000.
  - A=-4, B=-4 -> P=16.
  - Latency unchanged at 32 clocks.
